memory_write_arbiter: RTL and testbench

//  Shares the single write port of the memory neuron array among NREQ inter-neuron

---
 rtl/memory_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_memory_write_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_write_arbiter.sv
// Round-robin arbiter sharing one memory write port among NREQ channels,
// each buffered by a small FIFO, with memory back-pressure support.
module memory_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_code,
  output logic [NREQ-1:0]          req_full,
  output logic [NREQ-1:0]          ovf,
  input  logic                     clr_ovf,
  input  logic                     mem_busy,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  output logic [$clog2(NREQ)-1:0]  mem_src
);

  localparam int SW = $clog2(NREQ);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t         state;
  logic [AW-1:0]  fa [NREQ][DEPTH];
  logic [DW-1:0]  fd [NREQ][DEPTH];
  logic [PW-1:0]  wptr [NREQ];
  logic [PW-1:0]  rptr [NREQ];
  logic [SW-1:0]  ptr;
  logic [SW-1:0]  gnt;
  logic [SW-1:0]  nxt;
  logic           gnt_ok;
  logic           adv;
  logic           load;
  int             idx;
  logic [NREQ-1:0] nonempty;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] drop;
  logic [NREQ-1:0] pop;
  logic [NREQ-1:0] full_d;

  always_comb begin
    nonempty = '0;
    push     = '0;
    drop     = '0;
    pop      = '0;
    full_d   = '0;
    gnt      = '0;
    gnt_ok   = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      nonempty[i] = wptr[i] != rptr[i];
      push[i]     = req_we[i] & ~req_full[i];
      drop[i]     = req_we[i] & req_full[i];
    end
    // first non-empty FIFO at or after ptr, wrapping
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_ok && nonempty[idx]) begin
        gnt_ok = 1'b1;
        gnt    = SW'(idx);
      end
    end
    nxt  = (gnt == SW'(NREQ - 1)) ? '0 : gnt + SW'(1);
    adv  = (state == IDLE) | ~mem_busy;
    load = adv & gnt_ok;
    if (load) pop[gnt] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      full_d[i] = (wptr[i] + PW'(push[i]) - rptr[i] - PW'(pop[i]))
                  == PW'(DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_src  <= '0;
      req_full <= '0;
      ovf      <= '0;
      for (int i = 0; i < NREQ; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          fa[i][d] <= '0;
          fd[i][d] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (push[i]) begin
          fa[i][wptr[i][IW-1:0]] <= req_addr[i*AW +: AW];
          fd[i][wptr[i][IW-1:0]] <= req_code[i*DW +: DW];
          wptr[i] <= wptr[i] + PW'(1);
        end
        if (pop[i]) rptr[i] <= rptr[i] + PW'(1);
        if (drop[i]) ovf[i] <= 1'b1;
        else if (clr_ovf) ovf[i] <= 1'b0;
      end
      req_full <= full_d;
      if (load) begin
        mem_addr <= fa[gnt][rptr[gnt][IW-1:0]];
        mem_data <= fd[gnt][rptr[gnt][IW-1:0]];
        mem_src  <= gnt;
        ptr      <= nxt;
      end
      unique case (state)
        IDLE: begin
          if (gnt_ok) begin
            state  <= WRITE;
            mem_we <= 1'b1;
          end
        end
        WRITE, HOLD: begin
          if (mem_busy) begin
            state <= HOLD;
          end else if (gnt_ok) begin
            state <= WRITE;
          end else begin
            state  <= IDLE;
            mem_we <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_write_arbiter.sv
// Directed + random bench for memory_write_arbiter against a
// queue-based transaction model of the channel FIFOs and write port.
module tb_memory_write_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int DW    = 12;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_we;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_code;
  logic [NREQ-1:0]     req_full;
  logic [NREQ-1:0]     ovf;
  logic                clr_ovf;
  logic                mem_busy;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_data;
  logic [1:0]          mem_src;

  memory_write_arbiter #(
    .NREQ(NREQ), .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_we(req_we), .req_addr(req_addr), .req_code(req_code),
    .req_full(req_full), .ovf(ovf), .clr_ovf(clr_ovf),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_src(mem_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t            q [NREQ][$];
  bit              cur_v;
  logic [AW-1:0]   cur_a;
  logic [DW-1:0]   cur_d;
  int              cur_s;
  int              rr;
  logic [NREQ-1:0] ovf_m;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) q[i].delete();
    cur_v = 0;
    cur_a = '0;
    cur_d = '0;
    cur_s = 0;
    rr    = 0;
    ovf_m = '0;
  endtask

  // state transition at one clock edge, using pre-edge contents
  task automatic model_edge();
    bit   pf [NREQ];
    bit   ne [NREQ];
    int   g;
    int   j;
    ent_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NREQ; i++) begin
      pf[i] = q[i].size() == DEPTH;
      ne[i] = q[i].size() != 0;
    end
    if (!cur_v || !mem_busy) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (rr + k) % NREQ;
        if (g < 0 && ne[j]) g = j;
      end
      if (g >= 0) begin
        e     = q[g].pop_front();
        cur_v = 1;
        cur_a = e.a;
        cur_d = e.d;
        cur_s = g;
        rr    = (g + 1) % NREQ;
      end else begin
        cur_v = 0;
      end
    end
    if (clr_ovf) ovf_m = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_we[i]) begin
        if (pf[i]) ovf_m[i] = 1'b1;
        else q[i].push_back('{req_addr[i*AW +: AW], req_code[i*DW +: DW]});
      end
    end
  endtask

  task automatic compare_all();
    logic [NREQ-1:0] full_m;
    for (int i = 0; i < NREQ; i++) full_m[i] = q[i].size() == DEPTH;
    chk("we", mem_we, cur_v);
    chk("addr", mem_addr, cur_a);
    chk("data", mem_data, cur_d);
    chk("src", mem_src, cur_s);
    chk("full", req_full, full_m);
    chk("ovf", ovf, ovf_m);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_req(input int ch, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_we[ch]             = 1'b1;
    req_addr[ch*AW +: AW]  = a;
    req_code[ch*DW +: DW]  = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, mem_data, 0);
    chk({tag, "_src"}, mem_src, 0);
    chk({tag, "_full"}, req_full, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  logic [DW-1:0] c5;
  int prev;
  int n1;

  initial begin
    rst_n    = 1'b0;
    req_we   = '0;
    req_addr = '0;
    req_code = '0;
    clr_ovf  = 1'b0;
    mem_busy = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // T2: all channels at once, served 0..3 from a fresh pointer
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), DW'($urandom));
    step();
    req_we = '0;
    for (int i = 0; i < NREQ; i++) begin
      step();
      chk("t2_we", mem_we, 1);
      chk("t2_src", mem_src, i);
      chk("t2_addr", mem_addr, i);
    end
    step();
    chk("t2_idle", mem_we, 0);

    // T1: single write, one-cycle latency
    set_req(0, 5'd3, 12'hC83);
    step();
    req_we = '0;
    chk("t1_pre", mem_we, 0);
    step();
    chk("t1_we", mem_we, 1);
    chk("t1_addr", mem_addr, 3);
    chk("t1_data", mem_data, 12'hC83);
    chk("t1_src", mem_src, 0);
    step();
    chk("t1_done", mem_we, 0);

    // T3: ch0 and ch2 share the port fairly
    prev = -1;
    for (int c = 0; c < 16; c++) begin
      if (c % 2 == 0 && c < 12) begin
        set_req(0, AW'($urandom), DW'($urandom));
        set_req(2, AW'($urandom), DW'($urandom));
      end
      step();
      req_we = '0;
      if (mem_we) begin
        if (prev >= 0) chk("t3_alt", mem_src != 2'(prev), 1);
        prev = int'(mem_src);
      end
    end
    chk("t3_ovf", ovf, 0);

    // T4: stall with ch0 stuck in HOLD, ch1 overflows its FIFO
    mem_busy = 1'b1;
    set_req(0, 5'd9, 12'h111);
    step();
    req_we = '0;
    step();
    step();
    set_req(1, 5'd1, 12'hA01);
    step();
    set_req(1, 5'd2, 12'hA02);
    step();
    chk("t4_full", req_full[1], 1);
    set_req(1, 5'd3, 12'hA03);
    step();
    req_we = '0;
    chk("t4_ovf", ovf[1], 1);
    chk("t4_full2", req_full[1], 1);
    mem_busy = 1'b0;
    n1 = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (mem_we && mem_src == 2'd1) n1++;
    end
    chk("t4_n1", n1, 2);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t4_clr", ovf, 0);

    // T5: three-cycle stall on an active write
    c5 = DW'($urandom);
    set_req(3, 5'd17, c5);
    step();
    req_we = '0;
    step();
    chk("t5_we", mem_we, 1);
    mem_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_hold_we", mem_we, 1);
      chk("t5_hold_addr", mem_addr, 17);
      chk("t5_hold_data", mem_data, c5);
      chk("t5_hold_src", mem_src, 3);
    end
    mem_busy = 1'b0;
    step();
    chk("t5_once", mem_we, 0);

    // T6: reset mid-burst
    set_req(0, AW'($urandom), DW'($urandom));
    set_req(1, AW'($urandom), DW'($urandom));
    set_req(2, AW'($urandom), DW'($urandom));
    step();
    req_we = '0;
    step();
    chk("t6_busy", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async");
    model_reset();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t6_quiet", mem_we, 0);
    end

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_we[i] = ($urandom_range(0, 2) == 0);
      end
      req_addr = NREQ*AW'($urandom);
      req_code = {$urandom, $urandom};
      mem_busy = ($urandom_range(0, 3) == 0);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      step();
    end
    req_we   = '0;
    mem_busy = 1'b0;
    clr_ovf  = 1'b0;
    for (int c = 0; c < 12; c++) step();
    chk("drain", mem_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
